// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC enable/next-PC, small fetch queue toward decode,
// redirect flush and RUN/DRAIN/HALTED control. Optional counters under FETCH_PERF_EN.
module fetch_ctrl #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_instr,
  input  logic [31:0] F_PC,
  output logic        pc_en,
  output logic [31:0] NPC,
  output logic        d_valid,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  input  logic        d_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic        halted,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];

  logic deq, full, fire;

  assign deq  = d_valid & d_ready;
  assign full = (count_q == (PTR_W+1)'(DEPTH));
  assign fire = (state_q == RUN) & (~full | deq) & ~redirect;

  // Reset gates the enable so the PC register never loads while held in reset.
  assign pc_en = (fire | redirect) & ~reset;
  assign NPC   = redirect ? redirect_target : F_PC + 32'd4;

  assign d_valid = (count_q != '0);
  assign d_instr = instr_mem[head_q];
  assign d_pc    = pc_mem[head_q];
  assign halted  = (state_q == HALTED);

  always_comb begin
    count_d = count_q;
    if (redirect) begin
      count_d = '0;
    end else begin
      case ({fire, deq})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // DRAIN decides on the post-dequeue/post-flush occupancy of this cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = DRAIN;
      DRAIN: begin
        if (!halt_req)          state_d = RUN;
        else if (count_d == '0) state_d = HALTED;
      end
      HALTED:  if (resume) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (redirect) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (fire) begin
          instr_mem[tail_q] <= F_instr;
          pc_mem[tail_q]    <= F_PC;
          tail_q            <= tail_q + PTR_W'(1);
        end
        if (deq) head_q <= head_q + PTR_W'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0]    bubble_q, flush_q;
  logic [PTR_W:0] deq_w;

  assign deq_w = {{PTR_W{1'b0}}, deq};

  // A flush only counts when something survives the same-cycle dequeue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if ((state_q == RUN) && !d_valid) bubble_q <= bubble_q + 32'd1;
      if (redirect && (count_q > deq_w)) flush_q <= flush_q + 32'd1;
    end
  end

  assign perf_bubble_cnt = bubble_q;
  assign perf_flush_cnt  = flush_q;
`else
  assign perf_bubble_cnt = 32'h0;
  assign perf_flush_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a simple PC register / IM model around it.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] F_instr;
  logic [31:0] F_PC = 32'h0;
  logic        pc_en;
  logic [31:0] NPC;
  logic        d_valid;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic        d_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic        halted;
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_flush_cnt;

  logic        pc_set = 1'b0;
  logic [31:0] pc_set_val = 32'h0;

  int n_cmp = 0;
  int n_fail = 0;

  fetch_ctrl #(.DEPTH(2), .PTR_W(1)) dut (
    .clk(clk), .reset(reset), .F_instr(F_instr), .F_PC(F_PC),
    .pc_en(pc_en), .NPC(NPC), .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc),
    .d_ready(d_ready), .redirect(redirect), .redirect_target(redirect_target),
    .halt_req(halt_req), .resume(resume), .halted(halted),
    .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  // PC register and instruction memory of the surrounding F stage.
  always @(posedge clk) begin
    if (pc_set)     F_PC <= pc_set_val;
    else if (pc_en) F_PC <= NPC;
  end
  assign F_instr = F_PC ^ 32'hDEAD0000;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] pc);
    @(negedge clk);
    reset = 1'b1; pc_set = 1'b1; pc_set_val = pc;
    d_ready = 1'b0; redirect = 1'b0; halt_req = 1'b0; resume = 1'b0;
    tick(); tick(); #1;
    n_cmp++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL rst_d_valid got %b want 0", d_valid); end
    n_cmp++; if (d_instr !== 32'h0) begin n_fail++; $display("FAIL rst_d_instr got %h want 0", d_instr); end
    n_cmp++; if (d_pc !== 32'h0) begin n_fail++; $display("FAIL rst_d_pc got %h want 0", d_pc); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got %b want 0", halted); end
    n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL rst_pc_en got %b want 0", pc_en); end
    n_cmp++; if (perf_bubble_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_bubble got %h want 0", perf_bubble_cnt); end
    n_cmp++; if (perf_flush_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_flush got %h want 0", perf_flush_cnt); end
    reset = 1'b0; pc_set = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(32'h3000);
    n_cmp++; if (F_PC !== 32'h3000) begin n_fail++; $display("FAIL rst_fpc got %h want 3000", F_PC); end
  endtask

  task automatic test_fetch();
    do_reset(32'h3000);
    d_ready = 1'b1; #1;
    n_cmp++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL fetch_pc_en got %b want 1", pc_en); end
    n_cmp++; if (NPC !== 32'h3004) begin n_fail++; $display("FAIL fetch_npc got %h want 3004", NPC); end
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      n_cmp++; if (d_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid%0d got %b want 1", k, d_valid); end
      n_cmp++; if (d_pc !== 32'h3000 + 32'(4*k)) begin n_fail++; $display("FAIL fetch_pc%0d got %h want %h", k, d_pc, 32'h3000 + 32'(4*k)); end
      n_cmp++; if (d_instr !== ((32'h3000 + 32'(4*k)) ^ 32'hDEAD0000)) begin n_fail++; $display("FAIL fetch_instr%0d got %h", k, d_instr); end
    end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_bubble_cnt !== 32'd1) begin n_fail++; $display("FAIL fetch_bubble got %0d want 1", perf_bubble_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    do_reset(32'h3000);
    #1;
    n_cmp++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL bp_pc_en0 got %b want 1", pc_en); end
    tick(); #1;
    n_cmp++; if (d_pc !== 32'h3000) begin n_fail++; $display("FAIL bp_head1 got %h want 3000", d_pc); end
    n_cmp++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL bp_pc_en1 got %b want 1", pc_en); end
    tick(); #1;
    n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL bp_full_pc_en got %b want 0", pc_en); end
    n_cmp++; if (F_PC !== 32'h3008) begin n_fail++; $display("FAIL bp_fpc got %h want 3008", F_PC); end
    tick(); #1;
    n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL bp_hold_pc_en got %b want 0", pc_en); end
    n_cmp++; if (d_pc !== 32'h3000) begin n_fail++; $display("FAIL bp_hold_head got %h want 3000", d_pc); end
    d_ready = 1'b1; #1;
    n_cmp++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL bp_deq_full_pc_en got %b want 1", pc_en); end
    tick(); #1;
    n_cmp++; if (d_pc !== 32'h3004) begin n_fail++; $display("FAIL bp_second got %h want 3004", d_pc); end
    tick(); #1;
    n_cmp++; if (d_pc !== 32'h3008) begin n_fail++; $display("FAIL bp_third got %h want 3008", d_pc); end
    n_cmp++; if (d_valid !== 1'b1) begin n_fail++; $display("FAIL bp_third_valid got %b want 1", d_valid); end
  endtask

  task automatic test_redirect();
    do_reset(32'h3000);
    tick(); tick();
    redirect = 1'b1; redirect_target = 32'h3100; d_ready = 1'b1; #1;
    n_cmp++; if (NPC !== 32'h3100) begin n_fail++; $display("FAIL redir_npc got %h want 3100", NPC); end
    n_cmp++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL redir_pc_en got %b want 1", pc_en); end
    n_cmp++; if (d_pc !== 32'h3000) begin n_fail++; $display("FAIL redir_head got %h want 3000", d_pc); end
    tick(); redirect = 1'b0; #1;
    n_cmp++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flushed got %b want 0", d_valid); end
    n_cmp++; if (F_PC !== 32'h3100) begin n_fail++; $display("FAIL redir_fpc got %h want 3100", F_PC); end
    tick(); #1;
    n_cmp++; if (d_pc !== 32'h3100) begin n_fail++; $display("FAIL redir_new_head got %h want 3100", d_pc); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_flush_cnt !== 32'd1) begin n_fail++; $display("FAIL redir_flush_cnt got %0d want 1", perf_flush_cnt); end
`endif
  endtask

  task automatic test_halt();
    do_reset(32'h3000);
    tick(); tick();
    halt_req = 1'b1; #1;
    n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL halt_full_pc_en got %b want 0", pc_en); end
    tick(); d_ready = 1'b1; #1;
    n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL halt_drain_pc_en got %b want 0", pc_en); end
    n_cmp++; if (d_pc !== 32'h3000) begin n_fail++; $display("FAIL halt_drain0 got %h want 3000", d_pc); end
    tick(); #1;
    n_cmp++; if (d_pc !== 32'h3004) begin n_fail++; $display("FAIL halt_drain1 got %h want 3004", d_pc); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_early got %b want 0", halted); end
    tick(); #1;
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted got %b want 1", halted); end
    n_cmp++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL halt_empty got %b want 0", d_valid); end
    tick(); #1;
    n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL halt_stay_pc_en got %b want 0", pc_en); end
    halt_req = 1'b0; resume = 1'b1; #1;
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_resume_cycle got %b want 1", halted); end
    tick(); resume = 1'b0; #1;
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_resumed got %b want 0", halted); end
    n_cmp++; if (NPC !== 32'h300C) begin n_fail++; $display("FAIL halt_resume_npc got %h want 300c", NPC); end
    n_cmp++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL halt_resume_pc_en got %b want 1", pc_en); end
    tick(); #1;
    n_cmp++; if (d_pc !== 32'h3008) begin n_fail++; $display("FAIL halt_restart_pc got %h want 3008", d_pc); end
  endtask

  task automatic test_halted_redirect();
    do_reset(32'h3000);
    halt_req = 1'b1;
    tick(); d_ready = 1'b1; #1;
    n_cmp++; if (d_pc !== 32'h3000) begin n_fail++; $display("FAIL hr_last_word got %h want 3000", d_pc); end
    tick(); #1;
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL hr_halted got %b want 1", halted); end
    redirect = 1'b1; redirect_target = 32'h4180; #1;
    n_cmp++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL hr_pc_en got %b want 1", pc_en); end
    n_cmp++; if (NPC !== 32'h4180) begin n_fail++; $display("FAIL hr_npc got %h want 4180", NPC); end
    tick(); redirect = 1'b0; #1;
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL hr_still_halted got %b want 1", halted); end
    n_cmp++; if (F_PC !== 32'h4180) begin n_fail++; $display("FAIL hr_fpc got %h want 4180", F_PC); end
    halt_req = 1'b0; resume = 1'b1;
    tick(); resume = 1'b0; #1;
    n_cmp++; if (NPC !== 32'h4184) begin n_fail++; $display("FAIL hr_resume_npc got %h want 4184", NPC); end
    tick(); #1;
    n_cmp++; if (d_pc !== 32'h4180) begin n_fail++; $display("FAIL hr_target_head got %h want 4180", d_pc); end
    resume = 1'b1;
    tick(); resume = 1'b0; #1;
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL hr_resume_in_run got %b want 0", halted); end
    n_cmp++; if (d_pc !== 32'h4184) begin n_fail++; $display("FAIL hr_run_stream got %h want 4184", d_pc); end
  endtask

  task automatic test_wrap_reset();
    do_reset(32'h3000);
    d_ready = 1'b1; redirect = 1'b1; redirect_target = 32'hFFFFFFFC; #1;
    n_cmp++; if (NPC !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_redir_npc got %h want fffffffc", NPC); end
    tick(); redirect = 1'b0; #1;
    n_cmp++; if (NPC !== 32'h00000000) begin n_fail++; $display("FAIL wrap_npc got %h want 0", NPC); end
    tick(); #1;
    n_cmp++; if (d_pc !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_head got %h want fffffffc", d_pc); end
    n_cmp++; if (d_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got %b want 1", d_valid); end
    #1; reset = 1'b1; #1;
    n_cmp++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got %b want 0", d_valid); end
    n_cmp++; if (d_pc !== 32'h0) begin n_fail++; $display("FAIL async_rst_pc got %h want 0", d_pc); end
    n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL async_rst_pc_en got %b want 0", pc_en); end
    tick(); reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_backpressure();
    test_redirect();
    test_halt();
    test_halted_redirect();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch stage: drives the PC enable and next-PC, and buffers fetched words in a small FIFO toward decode.
- Handles decode back-pressure through a valid/ready handshake, redirects (branch, jump, exception vector), and a halt/drain/resume state machine.
- Sits between the PC/IM fetch pair and the D-stage pipeline register.

Parameters:
- DEPTH, 2, fetch-queue entries; power of two, 2..8.
- PTR_W, 1, pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- F_instr  in  32  instruction word read from IM at F_PC.
- F_PC  in  32  current PC register value.
- pc_en  out  1  PC load enable.
- NPC  out  32  next PC loaded when pc_en=1.
- d_valid  out  1  queue head valid toward decode.
- d_instr  out  32  head instruction.
- d_pc  out  32  head PC.
- d_ready  in  1  decode accepts head this cycle; 0 = stall.
- redirect  in  1  one-cycle redirect request.
- redirect_target  in  32  new fetch address.
- halt_req  in  1  level request to stop fetching.
- resume  in  1  pulse; leave HALTED.
- halted  out  1  state==HALTED.
- perf_bubble_cnt  out  32  optional counter; see Optional Feature.
- perf_flush_cnt  out  32  optional counter; see Optional Feature.

Behaviour:
- Reset (async) clears state to RUN, count/pointers to 0 and all queue storage to 0.
  - Outputs during reset: d_valid=0, d_instr=0, d_pc=0, halted=0, pc_en=0.
- Internal signals:
  - deq = d_valid & d_ready.
  - full = (count==DEPTH).
  - fire = (state==RUN) & (~full | deq) & ~redirect.
- pc_en = fire | redirect. The redirect path is active in every state.
- NPC = redirect ? redirect_target : F_PC+4. Addition is mod 2^32 and wraps with no flag.
- Enqueue on fire:
  - {F_instr, F_PC} is written at the tail; the tail pointer wraps mod DEPTH.
  - Latency: a word fetched in cycle N appears at d_* in cycle N+1 if the queue was empty.
- Head outputs:
  - d_valid = (count!=0).
  - d_instr and d_pc come from registered head storage, with no combinational path from F_instr.
- Same-cycle deq and fire at full: both take effect and count is unchanged.
- Redirect:
  - The deq handshake in the same cycle still completes.
  - All remaining entries are flushed; count becomes 0 next cycle.
  - The word currently at F_instr is discarded, not enqueued.
  - The decode stage asserts redirect only after the delay-slot word has been dequeued.
- FSM:
  - RUN: halt_req=1 -> DRAIN.
  - DRAIN: no fire. halt_req=0 -> RUN. Otherwise, when count==0 (after any deq or redirect this cycle) -> HALTED.
  - HALTED: halted=1, no fire. resume=1 -> RUN the next cycle, and fetch restarts from the current F_PC.
  - resume outside HALTED is ignored.
- Redirect while HALTED loads the PC so that resume fetches from the target. halted stays 1.
- redirect and halt_req in the same cycle: both take effect.
- Reset asserted mid-operation discards the queue immediately.
- Empty queue: d_valid=0 and d_ready is ignored.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined:
  - perf_bubble_cnt increments every cycle with state==RUN & d_valid=0.
  - perf_flush_cnt increments by 1 per redirect that discards at least one valid entry.
  - Both counters are 32-bit, wrap, and reset to 0.
- Undefined: both ports are tied to 32'h0 and no counter flops exist.

Test Plan:
1. Reset release with F_PC=0x3000 and d_ready=1.
   - Cycle 1: pc_en=1, NPC=0x3004.
   - Cycle 2: d_valid=1, d_pc=0x3000.
   - Then one word per cycle.
2. DEPTH=2, hold d_ready=0.
   - Queue fills with 0x3000 and 0x3004, then pc_en=0. F_PC holds at 0x3008.
   - Raise d_ready: 0x3000, 0x3004, 0x3008 are delivered in order with no gap.
3. With 2 valid entries, assert redirect, redirect_target=0x3100 and d_ready=1.
   - Head 0x3000 is consumed.
   - Next cycle: d_valid=0, then d_pc=0x3100.
   - With FETCH_PERF_EN: perf_flush_cnt=1.
4. Halt sequence:
   - Assert halt_req with 2 entries queued. Queue drains, then halted=1 and pc_en stays 0.
   - Pulse resume with halt_req=0: fetch restarts at the held F_PC.
5. In HALTED, redirect to 0x4180, then resume.
   - Next cycle: d_pc=0x4180.
   - resume pulsed in RUN has no effect.
6. Wrap and mid-operation reset:
   - redirect_target=0xFFFFFFFC gives NPC=0x00000000.
   - Async reset mid-stream forces d_valid=0 in the same cycle, without waiting for a clock edge.
